// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the ID-stage pipeline/CGRA glue and hazard_stall_ctrl.
// master = pipeline side driving hazard/handshake inputs, slave = the controller.
interface hazard_stall_ctrl_if;
    logic        IDEX_MemRead_i;
    logic [4:0]  IDEX_RegDst_i;
    logic [4:0]  IFID_RS1_i;
    logic [4:0]  IFID_RS2_i;
    logic        IFID_CgraOp_i;
    logic        mem_stall_i;
    logic        cgra_ready_i;
    logic        cgra_done_i;
    logic        Stall_o;
    logic        PCWrite_o;
    logic        IFIDWrite_o;
    logic        cgra_start_o;
    logic        cgra_busy_o;
    logic        timeout_o;
    logic [15:0] stall_cnt_o;

    modport master (
        output IDEX_MemRead_i, IDEX_RegDst_i, IFID_RS1_i, IFID_RS2_i,
               IFID_CgraOp_i, mem_stall_i, cgra_ready_i, cgra_done_i,
        input  Stall_o, PCWrite_o, IFIDWrite_o, cgra_start_o, cgra_busy_o,
               timeout_o, stall_cnt_o
    );

    modport slave (
        input  IDEX_MemRead_i, IDEX_RegDst_i, IFID_RS1_i, IFID_RS2_i,
               IFID_CgraOp_i, mem_stall_i, cgra_ready_i, cgra_done_i,
        output Stall_o, PCWrite_o, IFIDWrite_o, cgra_start_o, cgra_busy_o,
               timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// ID-stage stall controller: load-use, memory-busy and CGRA offload handshake stalls.
// Optional CGRA watchdog enabled by defining HAZARD_STALL_CTRL_TIMEOUT_EN.
module hazard_stall_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    hazard_stall_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        timeout_q, timeout_d;
    logic        hz_s, stall_s, start_s, busy_s, go_s, qual_done_s, expire_s, stall_out_s;

    assign hz_s = bus.IDEX_MemRead_i && (bus.IDEX_RegDst_i != 5'd0) &&
                  ((bus.IDEX_RegDst_i == bus.IFID_RS1_i) || (bus.IDEX_RegDst_i == bus.IFID_RS2_i));
    assign busy_s = (state_q == S_REQ) || (state_q == S_WAIT);
    assign go_s   = (state_q == S_IDLE) && bus.IFID_CgraOp_i && !hz_s && !bus.mem_stall_i;
    assign qual_done_s = ((state_q == S_REQ) && bus.cgra_ready_i && bus.cgra_done_i) ||
                         ((state_q == S_WAIT) && bus.cgra_done_i);

`ifdef HAZARD_STALL_CTRL_TIMEOUT_EN
    logic [CNT_W-1:0] tcnt_q, tcnt_d;

    assign expire_s  = busy_s && (tcnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_d = timeout_q || (expire_s && !qual_done_s);

    // Watchdog counter: restarts on handshake entry, runs while the handshake is open
    always_comb begin
        tcnt_d = tcnt_q;
        if (go_s) begin
            tcnt_d = {CNT_W{1'b0}};
        end else if (busy_s) begin
            tcnt_d = tcnt_q + CNT_W'(1);
        end else begin
            tcnt_d = tcnt_q;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            tcnt_q <= {CNT_W{1'b0}};
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`else
    logic unused_cfg_s;
    assign unused_cfg_s = ^{32'(TIMEOUT_CYCLES), 32'(CNT_W)};
    assign expire_s     = 1'b0;
    assign timeout_d    = 1'b0;
`endif

    // Next-state and stall/start decode
    always_comb begin
        state_d = state_q;
        stall_s = 1'b0;
        start_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall_s = bus.mem_stall_i || hz_s || bus.IFID_CgraOp_i;
                if (go_s) state_d = S_REQ;
                else      state_d = S_IDLE;
            end
            S_REQ: begin
                stall_s = 1'b1;
                start_s = 1'b1;
                if (qual_done_s || expire_s) state_d = S_DRAIN;
                else if (bus.cgra_ready_i)   state_d = S_WAIT;
                else                         state_d = S_REQ;
            end
            S_WAIT: begin
                stall_s = 1'b1;
                if (qual_done_s || expire_s) state_d = S_DRAIN;
                else                         state_d = S_WAIT;
            end
            S_DRAIN: begin
                stall_s = bus.mem_stall_i;
                if (!bus.mem_stall_i) state_d = S_IDLE;
                else                  state_d = S_DRAIN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign stall_out_s = rst_i && stall_s;

    // Saturating stall-cycle counter
    always_comb begin
        if (stall_out_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, counter and sticky timeout registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            stall_cnt_q <= 16'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Reset forces the pipeline-facing outputs to their released values
    assign bus.Stall_o      = stall_out_s;
    assign bus.PCWrite_o    = !stall_out_s;
    assign bus.IFIDWrite_o  = !stall_out_s;
    assign bus.cgra_start_o = rst_i && start_s;
    assign bus.cgra_busy_o  = rst_i && busy_s;
    assign bus.timeout_o    = rst_i && timeout_q;
    assign bus.stall_cnt_o  = stall_cnt_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_hazard_stall_ctrl;
`ifdef HAZARD_STALL_CTRL_TIMEOUT_EN
    localparam int TO_CYC = 8;
    localparam bit TO_EN  = 1'b1;
`else
    localparam int TO_CYC = 255;
    localparam bit TO_EN  = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl #(.TIMEOUT_CYCLES(TO_CYC), .CNT_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: an offload transaction is "open" from acceptance until done,
    // "granted" once the CGRA took the request, then one drain phase before release.
    bit m_open, m_granted, m_drain, m_timeout;
    int m_cnt, m_elapsed;

    function automatic bit m_hz();
        return bus.IDEX_MemRead_i && (bus.IDEX_RegDst_i != 5'd0) &&
               (bus.IDEX_RegDst_i == bus.IFID_RS1_i || bus.IDEX_RegDst_i == bus.IFID_RS2_i);
    endfunction

    function automatic bit m_stall();
        if (!rst)         return 1'b0;
        else if (m_open)  return 1'b1;
        else if (m_drain) return bus.mem_stall_i;
        else              return bus.mem_stall_i || m_hz() || bus.IFID_CgraOp_i;
    endfunction

    function automatic void model_update();
        bit finished;
        if (!rst) begin
            m_open = 0; m_granted = 0; m_drain = 0; m_timeout = 0; m_cnt = 0; m_elapsed = 0;
        end else begin
            if (m_stall() && m_cnt < 65535) m_cnt++;
            if (m_drain) begin
                if (!bus.mem_stall_i) m_drain = 0;
            end else if (m_open) begin
                m_elapsed++;
                finished = m_granted ? bus.cgra_done_i : (bus.cgra_ready_i && bus.cgra_done_i);
                if (finished) begin
                    m_open = 0; m_drain = 1;
                end else if (TO_EN && m_elapsed == TO_CYC) begin
                    m_open = 0; m_drain = 1; m_timeout = 1;
                end else if (bus.cgra_ready_i) begin
                    m_granted = 1;
                end
            end else if (bus.IFID_CgraOp_i && !m_hz() && !bus.mem_stall_i) begin
                m_open = 1; m_granted = 0; m_elapsed = 0;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        bus.IDEX_MemRead_i = 1'b0; bus.IDEX_RegDst_i = 5'd0;
        bus.IFID_RS1_i = 5'd0; bus.IFID_RS2_i = 5'd0; bus.IFID_CgraOp_i = 1'b0;
        bus.mem_stall_i = 1'b0; bus.cgra_ready_i = 1'b0; bus.cgra_done_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        step(); step();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        bus.IFID_CgraOp_i = 1'b1; bus.mem_stall_i = 1'b1;
        #1;
        total++;
        if ({bus.Stall_o, bus.PCWrite_o, bus.IFIDWrite_o, bus.cgra_start_o, bus.cgra_busy_o, bus.timeout_o} !== 6'b011000) begin
            bad++; $display("FAIL reset_outputs got=%b want=011000",
                {bus.Stall_o, bus.PCWrite_o, bus.IFIDWrite_o, bus.cgra_start_o, bus.cgra_busy_o, bus.timeout_o});
        end
        step();
        total++;
        if (bus.stall_cnt_o !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bus.stall_cnt_o); end
        do_reset();
        total++;
        if (bus.Stall_o !== 1'b0) begin bad++; $display("FAIL reset_idle_stall got=%b want=0", bus.Stall_o); end
    endtask

    task automatic test_load_use();
        do_reset();
        bus.IDEX_MemRead_i = 1'b1; bus.IDEX_RegDst_i = 5'd5; bus.IFID_RS2_i = 5'd5; bus.IFID_RS1_i = 5'd2;
        #1;
        total++;
        if ({bus.Stall_o, bus.PCWrite_o, bus.IFIDWrite_o} !== 3'b100) begin
            bad++; $display("FAIL load_use_stall got=%b want=100", {bus.Stall_o, bus.PCWrite_o, bus.IFIDWrite_o});
        end
        step();
        bus.IDEX_MemRead_i = 1'b0; bus.IDEX_RegDst_i = 5'd0;
        #1;
        total++;
        if ({bus.Stall_o, bus.PCWrite_o} !== 2'b01) begin
            bad++; $display("FAIL load_use_release got=%b want=01", {bus.Stall_o, bus.PCWrite_o});
        end
        step();
        total++;
        if (bus.stall_cnt_o !== 16'd1) begin bad++; $display("FAIL load_use_cnt got=%0d want=1", bus.stall_cnt_o); end
    endtask

    task automatic test_x0_load();
        do_reset();
        bus.IDEX_MemRead_i = 1'b1; bus.IDEX_RegDst_i = 5'd0; bus.IFID_RS1_i = 5'd0; bus.IFID_RS2_i = 5'd0;
        #1;
        total++;
        if (bus.Stall_o !== 1'b0) begin bad++; $display("FAIL x0_load got=%b want=0", bus.Stall_o); end
        step();
        clear_inputs();
    endtask

    task automatic test_cgra_seq();
        logic [2:0] exp_ssb [0:5];   // {Stall, start, busy} at t..t+5
        exp_ssb = '{3'b100, 3'b111, 3'b111, 3'b101, 3'b101, 3'b101};
        do_reset();
        bus.IFID_CgraOp_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.cgra_ready_i = (c == 2);
            bus.cgra_done_i  = (c == 5);
            #1;
            total++;
            if ({bus.Stall_o, bus.cgra_start_o, bus.cgra_busy_o} !== exp_ssb[c]) begin
                bad++; $display("FAIL cgra_seq_t%0d got=%b want=%b", c,
                    {bus.Stall_o, bus.cgra_start_o, bus.cgra_busy_o}, exp_ssb[c]);
            end
            step();
        end
        bus.cgra_done_i = 1'b0;
        #1;
        total++;
        if ({bus.Stall_o, bus.PCWrite_o, bus.cgra_busy_o} !== 3'b010) begin
            bad++; $display("FAIL cgra_drain got=%b want=010", {bus.Stall_o, bus.PCWrite_o, bus.cgra_busy_o});
        end
        step();
        bus.IFID_CgraOp_i = 1'b0;
        #1;
        total++;
        if ({bus.Stall_o, bus.cgra_busy_o, bus.stall_cnt_o} !== {2'b00, 16'd6}) begin
            bad++; $display("FAIL cgra_idle got=%b/%0d want=00/6", {bus.Stall_o, bus.cgra_busy_o}, bus.stall_cnt_o);
        end
    endtask

    task automatic test_ready_done_same();
        do_reset();
        bus.IFID_CgraOp_i = 1'b1;
        step();
        bus.cgra_ready_i = 1'b1; bus.cgra_done_i = 1'b1;
        #1;
        total++;
        if (bus.cgra_busy_o !== 1'b1) begin bad++; $display("FAIL rd_same_busy got=%b want=1", bus.cgra_busy_o); end
        step();
        clear_inputs();
        #1;
        total++;
        if ({bus.Stall_o, bus.cgra_start_o, bus.cgra_busy_o} !== 3'b000) begin
            bad++; $display("FAIL rd_same_drain got=%b want=000", {bus.Stall_o, bus.cgra_start_o, bus.cgra_busy_o});
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.IFID_CgraOp_i = 1'b1;
        step();
        bus.IFID_CgraOp_i = 1'b0; bus.cgra_ready_i = 1'b1;
        step();
        bus.cgra_ready_i = 1'b0;
        step();
        rst = 1'b0;
        #1;
        total++;
        if ({bus.Stall_o, bus.PCWrite_o, bus.cgra_start_o, bus.cgra_busy_o} !== 4'b0100) begin
            bad++; $display("FAIL rst_mid_forced got=%b want=0100",
                {bus.Stall_o, bus.PCWrite_o, bus.cgra_start_o, bus.cgra_busy_o});
        end
        step();
        rst = 1'b1;
        #1;
        total++;
        if ({bus.Stall_o, bus.cgra_busy_o, bus.stall_cnt_o} !== {2'b00, 16'd0}) begin
            bad++; $display("FAIL rst_mid_after got=%b/%0d want=00/0", {bus.Stall_o, bus.cgra_busy_o}, bus.stall_cnt_o);
        end
        step();
    endtask

`ifdef HAZARD_STALL_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        bus.IFID_CgraOp_i = 1'b1;
        step();
        bus.IFID_CgraOp_i = 1'b0;
        for (int c = 1; c <= TO_CYC; c++) begin
            #1;
            total++;
            if ({bus.cgra_busy_o, bus.timeout_o} !== 2'b10) begin
                bad++; $display("FAIL timeout_wait_c%0d got=%b want=10", c, {bus.cgra_busy_o, bus.timeout_o});
            end
            step();
        end
        total++;
        if ({bus.cgra_busy_o, bus.timeout_o, bus.Stall_o} !== 3'b010) begin
            bad++; $display("FAIL timeout_fire got=%b want=010", {bus.cgra_busy_o, bus.timeout_o, bus.Stall_o});
        end
        step(); step();
        total++;
        if (bus.timeout_o !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b want=1", bus.timeout_o); end
        rst = 1'b0;
        #1;
        total++;
        if (bus.timeout_o !== 1'b0) begin bad++; $display("FAIL timeout_rst got=%b want=0", bus.timeout_o); end
        step();
        rst = 1'b1;
    endtask
`endif

    task automatic test_random();
        logic [21:0] got, exp;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 79) != 0);
            bus.IDEX_MemRead_i = 1'($urandom_range(0, 1));
            bus.IDEX_RegDst_i  = 5'($urandom_range(0, 3));
            bus.IFID_RS1_i     = 5'($urandom_range(0, 3));
            bus.IFID_RS2_i     = 5'($urandom_range(0, 3));
            bus.IFID_CgraOp_i  = ($urandom_range(0, 2) == 0);
            bus.mem_stall_i    = ($urandom_range(0, 4) == 0);
            bus.cgra_ready_i   = ($urandom_range(0, 2) == 0);
            bus.cgra_done_i    = ($urandom_range(0, 5) == 0);
            #1;
            got = {bus.Stall_o, bus.PCWrite_o, bus.IFIDWrite_o, bus.cgra_start_o,
                   bus.cgra_busy_o, bus.timeout_o, bus.stall_cnt_o};
            exp = {m_stall(), !m_stall(), !m_stall(), rst && m_open && !m_granted,
                   rst && m_open, rst && m_timeout, 16'(m_cnt)};
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL random_cycle%0d got=%h want=%h", i, got, exp);
            end
            step();
        end
        clear_inputs();
        rst = 1'b1;
    endtask

    initial begin
        clear_inputs();
        m_open = 0; m_granted = 0; m_drain = 0; m_timeout = 0; m_cnt = 0; m_elapsed = 0;
        #2;
        test_reset();
        test_load_use();
        test_x0_load();
        test_cgra_seq();
        test_ready_done_same();
        test_reset_mid();
`ifdef HAZARD_STALL_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline stall controller for the RISC-V core with CGRA offload. It produces the `Stall` signal consumed by the ID-stage control-signal mux, along with the matching PC and IF/ID write enables. Stall sources are load-use hazards, data-memory busy, and the multi-cycle CGRA offload request/completion handshake. It sits in the ID stage beside the hazard-detection and control logic.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in CGRA_REQ plus CGRA_WAIT before a forced release. Used only with the timeout feature.
- `CNT_W`, default 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `IDEX_MemRead_i`  in  1  instruction in EX is a load.
- `IDEX_RegDst_i`  in  5  destination register of the instruction in EX.
- `IFID_RS1_i`  in  5  rs1 of the instruction in ID.
- `IFID_RS2_i`  in  5  rs2 of the instruction in ID.
- `IFID_CgraOp_i`  in  1  instruction in ID is a CGRA offload op.
- `mem_stall_i`  in  1  data memory busy.
- `cgra_ready_i`  in  1  CGRA accepts the request.
- `cgra_done_i`  in  1  CGRA kernel complete, 1-cycle pulse.
- `Stall_o`  out  1  to the control mux; 1 holds the ID/EX control signals.
- `PCWrite_o`  out  1  PC write enable. Always ~Stall_o.
- `IFIDWrite_o`  out  1  IF/ID write enable. Always ~Stall_o.
- `cgra_start_o`  out  1  request valid to the CGRA.
- `cgra_busy_o`  out  1  FSM is in CGRA_REQ or CGRA_WAIT.
- `timeout_o`  out  1  sticky CGRA timeout flag.
- `stall_cnt_o`  out  16  saturating count of stall cycles.

## Operation
- Load-use hazard: `hz` = `IDEX_MemRead_i` & (`IDEX_RegDst_i` != 0) & (`IDEX_RegDst_i` == `IFID_RS1_i` | `IDEX_RegDst_i` == `IFID_RS2_i`). It is combinational.
- FSM states: IDLE, CGRA_REQ, CGRA_WAIT, CGRA_DRAIN. Reset state is IDLE.
- IDLE:
  - Stall_o = `mem_stall_i` | `hz` | `IFID_CgraOp_i`.
  - Moves to CGRA_REQ when `IFID_CgraOp_i` & ~`hz` & ~`mem_stall_i`.
  - A load-use hazard or memory stall takes priority; the CGRA op waits in IDLE.
- CGRA_REQ:
  - Stall_o = 1 and `cgra_start_o` = 1.
  - `cgra_ready_i` moves to CGRA_WAIT.
  - `cgra_ready_i` & `cgra_done_i` in the same cycle moves directly to CGRA_DRAIN.
- CGRA_WAIT:
  - Stall_o = 1 and `cgra_start_o` = 0.
  - `cgra_done_i` moves to CGRA_DRAIN.
- CGRA_DRAIN:
  - Stall_o = `mem_stall_i`.
  - Moves to IDLE when ~`mem_stall_i`; otherwise stays in CGRA_DRAIN.
  - This is the cycle the CGRA op advances into ID/EX. `IFID_CgraOp_i` is ignored here, so the op does not retrigger.
- `cgra_done_i` and `cgra_ready_i` are ignored in IDLE and CGRA_DRAIN.
- `cgra_busy_o` = state is CGRA_REQ or CGRA_WAIT.
- `stall_cnt_o` increments at each clock edge where Stall_o = 1. It saturates at 0xFFFF and is cleared only by reset.
- While `rst_i` = 0, outputs are forced regardless of other inputs:
  - Stall_o = 0, PCWrite_o = 1, IFIDWrite_o = 1.
  - cgra_start_o = 0, cgra_busy_o = 0, timeout_o = 0.
  - stall_cnt_o = 0 at the next edge.
- Reset asserted mid-handshake returns the FSM to IDLE at the next edge. The CGRA request is dropped without a done.

## Timing
- Stall_o, PCWrite_o, IFIDWrite_o and cgra_start_o are combinational from registered state plus inputs, with zero latency.
- State, stall_cnt_o and timeout_o are registered.
- A load-use hazard stalls exactly 1 cycle; the hazard clears on the next cycle because EX then holds the bubble.
- CGRA minimum sequence for an op in ID at cycle t with ready at t+1 and done at t+2:
  - Cycle t: IDLE, Stall_o = 1.
  - Cycle t+1: CGRA_REQ.
  - Cycle t+2: CGRA_WAIT.
  - Cycle t+3: CGRA_DRAIN with Stall_o = 0.
  - Result: 3 stall cycles.
- Handshake rule: `cgra_start_o` stays high continuously from entry to CGRA_REQ until the edge that samples `cgra_ready_i` = 1.

## Configuration
- Macro: `HAZARD_STALL_CTRL_TIMEOUT_EN`.
- Defined:
  - The CNT_W counter clears on entry to CGRA_REQ and increments each cycle in CGRA_REQ or CGRA_WAIT.
  - If the count reaches `TIMEOUT_CYCLES`-1 with no qualifying `cgra_done_i`, the FSM moves to CGRA_DRAIN and sets `timeout_o`.
  - `timeout_o` stays set until reset.
  - A `cgra_done_i` in that same final cycle takes the normal path and `timeout_o` is not set.
- Undefined:
  - No counter is built and `timeout_o` is tied to 0.
  - CGRA_WAIT waits indefinitely.

## Test plan
- Load-use: IDEX_MemRead_i = 1, IDEX_RegDst_i = 5, IFID_RS2_i = 5 for 1 cycle -> Stall_o = 1 and PCWrite_o = 0 for exactly 1 cycle; stall_cnt_o = 1.
- x0 load: IDEX_RegDst_i = 0 = IFID_RS1_i with MemRead = 1 -> Stall_o stays 0.
- CGRA op with ready at t+2 and done at t+5 -> cgra_start_o high for cycles t+1..t+2; Stall_o high for cycles t..t+5; Stall_o low at t+6 (DRAIN), then IDLE.
- Simultaneous ready and done in CGRA_REQ -> next state is CGRA_DRAIN; cgra_busy_o falls after 1 cycle.
- With the macro defined, TIMEOUT_CYCLES = 8 and no done -> forced CGRA_DRAIN 8 cycles after entering CGRA_REQ; timeout_o = 1 and stays 1 until rst_i = 0.
- rst_i = 0 during CGRA_WAIT -> at the next edge state is IDLE, stall_cnt_o = 0, Stall_o = 0.
